md_unit: RTL and testbench

Parametrised multiply/divide unit with its own funct decode, HI/LO registers and a stall handshake. It sits beside the combinational ALU and its control decode in the single-cycle MIPS datapath. It executes MULT/MULTU/DIV/DIVU iteratively in the background while unrelated instructions keep retiring. It stalls the core only when another HI/LO-class instruction arrives before the current operation finishes.

---
 rtl/md_unit.sv | 181 ++++++++++++++++++
 tb/tb_md_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers and a stall handshake.
// Start ops run in the background; only a later HI/LO-class op stalls while busy.
module md_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rtype,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    state_t             state_nx;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   dsr;
    logic [2*WIDTH-1:0] acc;
    logic               sgn_a;
    logic               sgn_b;
    logic               is_div;
    logic               dz;

    logic op_mult, op_multu, op_div, op_divu;
    logic mf_hi, mf_lo, mt_hi, mt_lo;
    logic start, signed_op, md_op, accept;

    always_comb begin
        op_mult  = 1'b0;
        op_multu = 1'b0;
        op_div   = 1'b0;
        op_divu  = 1'b0;
        mf_hi    = 1'b0;
        mf_lo    = 1'b0;
        mt_hi    = 1'b0;
        mt_lo    = 1'b0;
        if (rtype) begin
            case (funct)
                6'h18:   op_mult  = 1'b1;
                6'h19:   op_multu = 1'b1;
                6'h1A:   op_div   = 1'b1;
                6'h1B:   op_divu  = 1'b1;
                6'h10:   mf_hi    = 1'b1;
                6'h12:   mf_lo    = 1'b1;
                6'h11:   mt_hi    = 1'b1;
                6'h13:   mt_lo    = 1'b1;
                default: ;
            endcase
        end
    end

    assign start     = op_mult | op_multu | op_div | op_divu;
    assign signed_op = op_mult | op_div;
    assign md_op     = start | mf_hi | mf_lo | mt_hi | mt_lo;
    assign accept    = md_op & ~busy;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && start)
                      state_nx = (op_div | op_divu) ? DIV : MUL;
            MUL,
            DIV:  if (cnt == CW'(WIDTH-1)) state_nx = FIX;
            FIX:  state_nx = IDLE;
        endcase
    end

    // stall sees only state and decode, never the arithmetic
    always_comb begin
        busy  = (state != IDLE);
        stall = busy & md_op;
    end

    always_comb begin
        mf_data = '0;
        if (mf_hi)      mf_data = hi;
        else if (mf_lo) mf_data = lo;
    end

    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign neg_a = signed_op & rs_data[WIDTH-1];
    assign neg_b = signed_op & rt_data[WIDTH-1];
    assign mag_a = neg_a ? -rs_data : rs_data;
    assign mag_b = neg_b ? -rt_data : rt_data;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_try;
    logic [2*WIDTH-1:0] mul_nx;
    logic [2*WIDTH-1:0] div_nx;

    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + {1'b0, {WIDTH{acc[0]}} & dsr};
        sub_try = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dsr};
        mul_nx  = {add_sum, acc[WIDTH-1:1]};
        div_nx  = sub_try[WIDTH]
                ? {acc[2*WIDTH-2:0], 1'b0}
                : {sub_try[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // remainder keeps dividend sign, so divide-by-zero hands back rs unchanged
    always_comb begin
        quo  = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        prod = (sgn_a ^ sgn_b) ? -acc : acc;
        if (is_div) begin
            fix_lo = dz ? '1 : ((sgn_a ^ sgn_b) ? -quo : quo);
            fix_hi = sgn_a ? -rem : rem;
        end else begin
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt    <= '0;
            dsr    <= '0;
            acc    <= '0;
            sgn_a  <= 1'b0;
            sgn_b  <= 1'b0;
            is_div <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (accept && start) begin
                        acc    <= {{WIDTH{1'b0}}, mag_a};
                        dsr    <= mag_b;
                        sgn_a  <= neg_a;
                        sgn_b  <= neg_b;
                        is_div <= op_div | op_divu;
                        dz     <= (rt_data == '0);
                    end
                    if (accept && mt_hi) hi <= rs_data;
                    if (accept && mt_lo) lo <= rs_data;
                end
                MUL: begin
                    acc <= mul_nx;
                    cnt <= cnt + 1'b1;
                end
                DIV: begin
                    acc <= div_nx;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    hi <= fix_hi;
                    lo <= fix_lo;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: vector table, hand sequences and random ops vs. an arithmetic model.
// Covers a WIDTH=32 and a WIDTH=8 instance.
`timescale 1ns/1ps
module tb_md_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rtype = 1'b1;
    logic [5:0]  funct = 6'h20;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        stall, busy;
    logic [31:0] hi, lo, mf_data;

    logic        rtype8 = 1'b1;
    logic [5:0]  funct8 = 6'h20;
    logic [7:0]  rs8 = '0;
    logic [7:0]  rt8 = '0;
    logic        stall8, busy8;
    logic [7:0]  hi8, lo8, mf8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    md_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .rtype(rtype), .funct(funct),
        .rs_data(rs), .rt_data(rt), .stall(stall), .busy(busy),
        .hi(hi), .lo(lo), .mf_data(mf_data)
    );

    md_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .rtype(rtype8), .funct(funct8),
        .rs_data(rs8), .rt_data(rt8), .stall(stall8), .busy(busy8),
        .hi(hi8), .lo(lo8), .mf_data(mf8)
    );

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] h;
        logic [31:0] l;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // plain-arithmetic reference for one op at width w (w <= 32)
    function automatic void model(input logic [5:0] f,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input int w,
                                  output logic [31:0] h, output logic [31:0] l);
        longint m, ua, ub, sa, sb, p, q, r;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua >= (longint'(1) << (w-1))) ? ua - (longint'(1) << w) : ua;
        sb = (ub >= (longint'(1) << (w-1))) ? ub - (longint'(1) << w) : ub;
        p  = 0;
        case (f)
            6'h18: p = sa * sb;
            6'h19: p = ua * ub;
            default: begin
                if (ub == 0) begin
                    p = (ua << w) | m;
                end else begin
                    q = (f == 6'h1A) ? sa / sb : ua / ub;
                    r = (f == 6'h1A) ? sa % sb : ua % ub;
                    p = ((r & m) << w) | (q & m);
                end
            end
        endcase
        l = 32'(p & m);
        h = 32'((p >> w) & m);
    endfunction

    task automatic run_op(input int w, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b,
                          output int cyc);
        if (w == 8) begin
            funct8 = f; rs8 = a[7:0]; rt8 = b[7:0];
        end else begin
            funct = f; rs = a; rt = b;
        end
        @(posedge clk); #1;
        if (w == 8) funct8 = 6'h20;
        else        funct  = 6'h20;
        cyc = 0;
        while ((w == 8 ? busy8 : busy) && cyc < 100) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int n;
        logic [31:0] eh, el;
        logic [5:0]  f;
        logic [31:0] a, b;

        tbl[0] = '{6'h18, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        tbl[1] = '{6'h19, 32'd7, 32'hFFFFFFFD, 32'h00000006, 32'hFFFFFFEB};
        tbl[2] = '{6'h1B, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[3] = '{6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[4] = '{6'h1A, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF};
        tbl[5] = '{6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000};
        tbl[6] = '{6'h1B, 32'h80000007, 32'd0, 32'h80000007, 32'hFFFFFFFF};
        tbl[7] = '{6'h1A, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_stall", stall, 0);

        @(posedge clk); #1;
        rtype = 1'b0; funct = 6'h18; rs = 32'd3; rt = 32'd3;
        @(posedge clk); #1;
        chk("non_rtype_ignored", busy, 0);
        rtype = 1'b1; funct = 6'h20;

        for (int i = 0; i < 8; i++) begin
            run_op(32, tbl[i].f, tbl[i].a, tbl[i].b, cyc);
            chk($sformatf("vec%0d_busy_cycles", i), cyc, 33);
            chk($sformatf("vec%0d_hi", i), hi, tbl[i].h);
            chk($sformatf("vec%0d_lo", i), lo, tbl[i].l);
        end

        funct = 6'h18; rs = 32'd3; rt = 32'd4;
        @(posedge clk); #1;
        funct = 6'h20;
        @(negedge clk);
        chk("add_while_busy_stall", stall, 0);
        chk("add_while_busy_busy", busy, 1);
        @(posedge clk); #1;
        funct = 6'h12;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (!stall) break;
            n++;
            @(posedge clk); #1;
        end
        chk("mflo_stall_cycles", n, 32);
        chk("mflo_data", mf_data, 12);
        @(posedge clk); #1;
        funct = 6'h20;

        funct = 6'h11; rs = 32'hA5A5A5A5;
        @(negedge clk);
        chk("mthi_stall", stall, 0);
        @(posedge clk); #1;
        funct = 6'h10;
        @(negedge clk);
        chk("mfhi_data", mf_data, 32'hA5A5A5A5);
        chk("mfhi_stall", stall, 0);
        @(posedge clk); #1;
        funct = 6'h13; rs = 32'h00001234;
        @(posedge clk); #1;
        funct = 6'h20;
        chk("mtlo_lo", lo, 32'h00001234);

        funct = 6'h1B; rs = 32'd1000; rt = 32'd3;
        @(posedge clk); #1;
        funct = 6'h20;
        repeat (10) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midop_reset_busy", busy, 0);
        chk("midop_reset_hi", hi, 0);
        chk("midop_reset_lo", lo, 0);
        repeat (40) begin
            @(posedge clk); #1;
        end
        chk("no_late_write_hi", hi, 0);
        chk("no_late_write_lo", lo, 0);

        for (int i = 0; i < 40; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 9);
                2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                default: b = $urandom;
            endcase
            model(f, a, b, 32, eh, el);
            run_op(32, f, a, b, cyc);
            chk($sformatf("rnd%0d_f%h_cycles", i, f), cyc, 33);
            chk($sformatf("rnd%0d_f%h_%h_%h_hi", i, f, a, b), hi, eh);
            chk($sformatf("rnd%0d_f%h_%h_%h_lo", i, f, a, b), lo, el);
        end

        run_op(8, 6'h18, 32'h80, 32'h80, cyc);
        chk("w8_mult_cycles", cyc, 9);
        chk("w8_mult_hilo", {hi8, lo8}, 16'h4000);

        for (int i = 0; i < 20; i++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom_range(0, 255);
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(0, 255);
            model(f, a, b, 8, eh, el);
            run_op(8, f, a, b, cyc);
            chk($sformatf("w8_rnd%0d_cycles", i), cyc, 9);
            chk($sformatf("w8_rnd%0d_f%h_%h_%h_hilo", i, f, a[7:0], b[7:0]),
                {hi8, lo8}, {eh[7:0], el[7:0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
